// File: rtl/display_7seg_if.sv
// Signal bundle between the Hamming output multiplexer and the 2-digit seven-segment driver.
interface display_7seg_if;
  logic [3:0] s_mux;
  logic [1:0] e_mux;
  logic [6:0] seg;
  logic [1:0] an;
  logic       frame_tick;

  modport master (output s_mux, e_mux, input seg, an, frame_tick);
  modport slave  (input s_mux, e_mux, output seg, an, frame_tick);
endinterface

// File: rtl/display_7seg.sv
// Time-multiplexed 2-digit common-anode driver: hex nibble on digit 0, mode letter on digit 1.
// Inputs are shadowed once per frame; a mode change starts a frame-granular blink sequence.
module display_7seg #(
  parameter int unsigned REFRESH_DIV  = 50000,
  parameter int unsigned BLINK_FRAMES = 4
) (
  input logic            clk,
  input logic            rst,
  display_7seg_if.slave  bus
);

  localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned BLK_W = $clog2(BLINK_FRAMES + 1);

  typedef enum logic {
    SLOT_NIBBLE = 1'b0,
    SLOT_MODE   = 1'b1
  } slot_t;

  logic [CNT_W-1:0] ref_cnt_q, ref_cnt_d;
  slot_t            slot_q, slot_d;
  logic [3:0]       sh_dato_q, sh_dato_d;
  logic [1:0]       sh_modo_q, sh_modo_d;
  logic [BLK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic [6:0]       seg_q, seg_d;
  logic [1:0]       an_q, an_d;
  logic             frame_tick_q, frame_tick_d;

  logic             term_cnt;
  logic             boundary;
  logic [6:0]       nib_seg;
  logic [6:0]       mode_seg;

  always_comb begin
    unique case (sh_dato_q)
      4'h0: nib_seg = 7'b1000000;
      4'h1: nib_seg = 7'b1111001;
      4'h2: nib_seg = 7'b0100100;
      4'h3: nib_seg = 7'b0110000;
      4'h4: nib_seg = 7'b0011001;
      4'h5: nib_seg = 7'b0010010;
      4'h6: nib_seg = 7'b0000010;
      4'h7: nib_seg = 7'b1111000;
      4'h8: nib_seg = 7'b0000000;
      4'h9: nib_seg = 7'b0010000;
      4'hA: nib_seg = 7'b0001000;
      4'hB: nib_seg = 7'b0000011;
      4'hC: nib_seg = 7'b1000110;
      4'hD: nib_seg = 7'b0100001;
      4'hE: nib_seg = 7'b0000110;
      default: nib_seg = 7'b0001110;
    endcase
  end

  always_comb begin
    unique case (sh_modo_q)
      2'b01:   mode_seg = 7'b1000110;
      2'b10:   mode_seg = 7'b0000110;
      2'b11:   mode_seg = 7'b0010010;
      default: mode_seg = 7'b0111111;
    endcase
  end

  always_comb begin
    term_cnt     = (ref_cnt_q == CNT_W'(REFRESH_DIV - 1));
    boundary     = term_cnt && (slot_q == SLOT_MODE);

    ref_cnt_d    = term_cnt ? '0 : ref_cnt_q + CNT_W'(1);
    slot_d       = term_cnt ? slot_t'(~slot_q) : slot_q;
    sh_dato_d    = boundary ? bus.s_mux : sh_dato_q;
    sh_modo_d    = boundary ? bus.e_mux : sh_modo_q;
    frame_tick_d = boundary;

    // Reload wins over decrement so a mode change mid-blink restarts the sequence.
    blink_cnt_d = blink_cnt_q;
    if (boundary) begin
      if (bus.e_mux != sh_modo_q)
        blink_cnt_d = BLK_W'(BLINK_FRAMES);
      else if (blink_cnt_q != '0)
        blink_cnt_d = blink_cnt_q - BLK_W'(1);
    end

    if (blink_cnt_q[0]) begin
      an_d  = 2'b11;
      seg_d = '1;
    end else if (slot_q == SLOT_NIBBLE) begin
      an_d  = 2'b10;
      seg_d = nib_seg;
    end else begin
      an_d  = 2'b01;
      seg_d = mode_seg;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ref_cnt_q    <= '0;
      slot_q       <= SLOT_NIBBLE;
      sh_dato_q    <= '0;
      sh_modo_q    <= '0;
      blink_cnt_q  <= '0;
      seg_q        <= '1;
      an_q         <= '1;
      frame_tick_q <= 1'b0;
    end else begin
      ref_cnt_q    <= ref_cnt_d;
      slot_q       <= slot_d;
      sh_dato_q    <= sh_dato_d;
      sh_modo_q    <= sh_modo_d;
      blink_cnt_q  <= blink_cnt_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign bus.seg        = seg_q;
  assign bus.an         = an_q;
  assign bus.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_display_7seg.sv
// Directed bench for display_7seg with REFRESH_DIV=4, BLINK_FRAMES=2 (8-cycle frames).
module tb_display_7seg;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  int   ek = 0;
  int   ticks = 0;

  display_7seg_if bus ();

  display_7seg #(
    .REFRESH_DIV  (4),
    .BLINK_FRAMES (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // ek = number of rising edges since the last reset release; sample 1 time unit after the edge
  task automatic adv_to(input int k);
    while (ek < k) begin
      @(posedge clk);
      #1;
      ek++;
    end
  endtask

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s @edge %0d: observed %b expected %b", tag, ek, obs, exp);
    end
  endtask

  task automatic chk_disp(input string tag, input logic [1:0] an_e, input logic [6:0] seg_e);
    chk({tag, ".an"}, {5'b0, bus.an}, {5'b0, an_e});
    chk({tag, ".seg"}, bus.seg, seg_e);
  endtask

  initial begin
    bus.s_mux = 4'h0;
    bus.e_mux = 2'b00;

    // 1: reset and free-running refresh
    repeat (3) @(posedge clk);
    #1;
    chk_disp("rst_hold", 2'b11, 7'b1111111);
    chk("rst_tick", {6'b0, bus.frame_tick}, 7'd0);
    @(negedge clk);
    rst = 1'b0;
    ek  = 0;
    adv_to(1);  chk_disp("first_edge", 2'b10, 7'b1000000);
    adv_to(4);  chk_disp("slot0_end", 2'b10, 7'b1000000);
    adv_to(5);  chk_disp("slot1_dash", 2'b01, 7'b0111111);
    adv_to(7);  chk("no_tick_early", {6'b0, bus.frame_tick}, 7'd0);
    adv_to(8);  chk("tick_first", {6'b0, bus.frame_tick}, 7'd1);
    adv_to(9);  chk("tick_one_cycle", {6'b0, bus.frame_tick}, 7'd0);
    chk_disp("frame2_slot0", 2'b10, 7'b1000000);

    // 2: mode 01, nibble A; load at e16, blank only while blink_cnt is odd (e25..e32)
    bus.e_mux = 2'b01;
    bus.s_mux = 4'hA;
    adv_to(13); chk_disp("live_ignored", 2'b01, 7'b0111111);
    adv_to(17); chk_disp("cnt2_digit0", 2'b10, 7'b0001000);
    adv_to(21); chk_disp("cnt2_digit1", 2'b01, 7'b1000110);
    adv_to(25); chk_disp("cnt1_blank_a", 2'b11, 7'b1111111);
    adv_to(32); chk_disp("cnt1_blank_b", 2'b11, 7'b1111111);
    adv_to(33); chk_disp("A_shown", 2'b10, 7'b0001000);
    adv_to(37); chk_disp("C_shown", 2'b01, 7'b1000110);

    // 3: mode 10, nibble b; later a mid-frame nibble change with no mode change
    bus.e_mux = 2'b10;
    bus.s_mux = 4'hB;
    adv_to(41); chk_disp("b_digit0", 2'b10, 7'b0000011);
    adv_to(45); chk_disp("E_digit1", 2'b01, 7'b0000110);
    adv_to(49); chk_disp("b_blank", 2'b11, 7'b1111111);
    adv_to(57); chk_disp("b_steady", 2'b10, 7'b0000011);
    adv_to(58);
    bus.s_mux = 4'h5;
    adv_to(60); chk_disp("old_persists", 2'b10, 7'b0000011);
    adv_to(64); chk_disp("old_mode_digit", 2'b01, 7'b0000110);
    adv_to(65); chk_disp("new_5_no_blink", 2'b10, 7'b0010010);
    adv_to(69); chk_disp("E_no_blink", 2'b01, 7'b0000110);

    // 4: 10->01 loads at e72, cnt=1 at e80, then 01->11 at e88 reloads
    bus.e_mux = 2'b01;
    adv_to(81); chk_disp("cnt1_before_reload", 2'b11, 7'b1111111);
    adv_to(84);
    bus.e_mux = 2'b11;
    adv_to(88); chk_disp("still_blank_e88", 2'b11, 7'b1111111);
    adv_to(89); chk_disp("reload_digit0", 2'b10, 7'b0010010);
    adv_to(93); chk_disp("reload_S", 2'b01, 7'b0010010);
    adv_to(97); chk_disp("reload_blank_a", 2'b11, 7'b1111111);
    adv_to(104); chk_disp("reload_blank_b", 2'b11, 7'b1111111);
    adv_to(105); chk_disp("after_reload", 2'b10, 7'b0010010);
    adv_to(109); chk_disp("S_steady", 2'b01, 7'b0010010);

    // 5: blink again (load e112, blank e121..e128), reset in slot 1 of that frame
    bus.e_mux = 2'b10;
    adv_to(121); chk_disp("pre_rst_blank", 2'b11, 7'b1111111);
    adv_to(126);
    bus.e_mux = 2'b00;
    rst = 1'b1;
    #1;
    chk_disp("async_rst", 2'b11, 7'b1111111);
    chk("async_rst_tick", {6'b0, bus.frame_tick}, 7'd0);
    @(posedge clk);
    #1;
    chk_disp("rst_held", 2'b11, 7'b1111111);
    @(negedge clk);
    rst = 1'b0;
    ek  = 0;
    adv_to(1);  chk_disp("post_rst_first", 2'b10, 7'b1000000);
    adv_to(5);  chk_disp("post_rst_slot1", 2'b01, 7'b0111111);

    // 6: free run with mode 00 / nibble F; tick exactly at every 8th edge
    bus.s_mux = 4'hF;
    for (int k = 6; k <= 48; k++) begin
      adv_to(k);
      if (bus.frame_tick === 1'b1) ticks++;
      chk("tick_cadence", {6'b0, bus.frame_tick}, {6'b0, (k % 8 == 0)});
    end
    chk("tick_count", 7'(ticks), 7'd6);
    adv_to(49); chk_disp("F_digit0", 2'b10, 7'b0001110);
    adv_to(53); chk_disp("dash_digit1", 2'b01, 7'b0111111);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
